// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB pipeline register plus load alignment/extension and result select.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic            mem_regwrite,
  input  logic [1:0]      mem_wb_sel,
  input  logic [2:0]      mem_funct3,
  input  logic [XLEN-1:0] mem_alu_result,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [XLEN-1:0] mem_pc,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] wrt_data,
  output logic [4:0]      rd,
  output logic            RegWrite,
  output logic            wb_valid,
  output logic            load_misaligned
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]     retire_count
`endif
);

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_PC4  = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  logic            r_valid;
  logic [4:0]      r_rd;
  logic            r_regwrite;
  logic [1:0]      r_wb_sel;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_load_data;
  logic [XLEN-1:0] r_pc;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_rd         <= '0;
      r_regwrite   <= 1'b0;
      r_wb_sel     <= '0;
      r_funct3     <= '0;
      r_alu_result <= '0;
      r_load_data  <= '0;
      r_pc         <= '0;
    end else if (flush) begin
      // A bubble only needs valid cleared; the stale fields are harmless.
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_valid      <= mem_valid;
      r_rd         <= mem_rd;
      r_regwrite   <= mem_regwrite;
      r_wb_sel     <= mem_wb_sel;
      r_funct3     <= mem_funct3;
      r_alu_result <= mem_alu_result;
      r_load_data  <= mem_load_data;
      r_pc         <= mem_pc;
    end
  end

  logic [2:0]      offset;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] load_ext;
  logic            misaligned;

  assign offset  = r_alu_result[2:0];
  assign shifted = r_load_data >> {offset, 3'b000};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load_ext   = '0;
    misaligned = 1'b0;
    unique case (r_funct3)
      F3_LB:  load_ext = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LH:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_LW:  load_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_LD:  load_ext = shifted;
      F3_LBU: load_ext = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LHU: load_ext = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_LWU: load_ext = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_ext = '0;
    endcase
    unique case (r_funct3)
      F3_LH, F3_LHU: misaligned = offset[0];
      F3_LW, F3_LWU: misaligned = |offset[1:0];
      F3_LD:         misaligned = |offset;
      F3_LB, F3_LBU: misaligned = 1'b0;
      default:       misaligned = 1'b1;
    endcase
  end

  always_comb begin
    wrt_data = '0;
    unique case (r_wb_sel)
      SEL_ALU:  wrt_data = r_alu_result;
      SEL_LOAD: wrt_data = misaligned ? '0 : load_ext;
      SEL_PC4:  wrt_data = r_pc + XLEN'(4);
      default:  wrt_data = '0;
    endcase
  end

  assign rd              = r_rd;
  assign wb_valid        = r_valid;
  assign load_misaligned = r_valid & (r_wb_sel == SEL_LOAD) & misaligned;
  assign RegWrite        = r_valid & r_regwrite & (|r_rd) & ~load_misaligned
                         & (r_wb_sel != 2'b11);

`ifdef WB_RETIRE_CNT_EN
  // A held instruction retires once, on the edge where it finally leaves WB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count <= '0;
    end else if (r_valid && !stall) begin
      retire_count <= retire_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: transaction-level model checked every
// falling edge, plus hand-computed directed expectations.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic        mem_regwrite;
  logic [1:0]  mem_wb_sel;
  logic [2:0]  mem_funct3;
  logic [63:0] mem_alu_result;
  logic [63:0] mem_load_data;
  logic [63:0] mem_pc;
  logic        stall;
  logic        flush;
  logic [63:0] wrt_data;
  logic [4:0]  rd;
  logic        RegWrite;
  logic        wb_valid;
  logic        load_misaligned;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_count;
`endif

  int total = 0;
  int bad   = 0;

  writeback_stage #(.XLEN(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid      (mem_valid),
    .mem_rd         (mem_rd),
    .mem_regwrite   (mem_regwrite),
    .mem_wb_sel     (mem_wb_sel),
    .mem_funct3     (mem_funct3),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .mem_pc         (mem_pc),
    .stall          (stall),
    .flush          (flush),
    .wrt_data       (wrt_data),
    .rd             (rd),
    .RegWrite       (RegWrite),
    .wb_valid       (wb_valid),
    .load_misaligned(load_misaligned)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_count   (retire_count)
`endif
  );

  always #5 clk = ~clk;

  // The instruction the model believes is sitting in WB.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [63:0] alu;
    logic [63:0] ld;
    logic [63:0] pc;
  } instr_t;

  instr_t      m;
  logic [63:0] m_cnt;

  function automatic logic exp_mis_cond(instr_t x);
    int size;
    size = 1 << x.f3[1:0];
    return (x.f3 == 3'd7) || ((int'(x.alu[2:0]) % size) != 0);
  endfunction

  function automatic logic exp_lmis(instr_t x);
    return x.valid && x.sel == 2'd1 && exp_mis_cond(x);
  endfunction

  function automatic logic [63:0] exp_wrt(instr_t x);
    int bits;
    logic [63:0] v, mask;
    case (x.sel)
      2'd0: return x.alu;
      2'd2: return x.pc + 64'd4;
      2'd3: return 64'd0;
      default: begin
        if (exp_mis_cond(x)) return 64'd0;
        bits = 8 << x.f3[1:0];
        v    = x.ld >> (int'(x.alu[2:0]) * 8);
        if (bits == 64) return v;
        mask = (64'd1 << bits) - 64'd1;
        v    = v & mask;
        if (!x.f3[2] && v[bits-1]) v = v | ~mask;
        return v;
      end
    endcase
  endfunction

  function automatic logic exp_we(instr_t x);
    return x.valid && x.rw && x.rd != 5'd0 && !exp_lmis(x) && x.sel != 2'd3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m     <= '0;
      m_cnt <= '0;
    end else begin
      if (m.valid && !stall) m_cnt <= m_cnt + 64'd1;
      if (flush)       m.valid <= 1'b0;
      else if (!stall) m <= '{mem_valid, mem_rd, mem_regwrite, mem_wb_sel, mem_funct3,
                               mem_alu_result, mem_load_data, mem_pc};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cmp_valid", {63'd0, wb_valid}, {63'd0, m.valid});
    check("cmp_rd", {59'd0, rd}, {59'd0, m.rd});
    check("cmp_regwrite", {63'd0, RegWrite}, {63'd0, exp_we(m)});
    check("cmp_misaligned", {63'd0, load_misaligned}, {63'd0, exp_lmis(m)});
    if (m.valid || !rst_n) check("cmp_wrt_data", wrt_data, exp_wrt(m));
`ifdef WB_RETIRE_CNT_EN
    check("cmp_retire", retire_count, m_cnt);
`endif
  end

  task automatic drive(input logic v, input logic [4:0] r, input logic rw,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [63:0] alu, input logic [63:0] ld,
                       input logic [63:0] pc, input logic st, input logic fl);
    mem_valid = v; mem_rd = r; mem_regwrite = rw; mem_wb_sel = sel;
    mem_funct3 = f3; mem_alu_result = alu; mem_load_data = ld; mem_pc = pc;
    stall = st; flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [63:0] wd, input logic [4:0] r,
                           input logic we, input logic v, input logic mis);
    check({name, "_wrt"}, wrt_data, wd);
    check({name, "_rd"}, {59'd0, rd}, {59'd0, r});
    check({name, "_we"}, {63'd0, RegWrite}, {63'd0, we});
    check({name, "_valid"}, {63'd0, wb_valid}, {63'd0, v});
    check({name, "_mis"}, {63'd0, load_misaligned}, {63'd0, mis});
  endtask

  logic [63:0] c0;

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check_out("reset", 64'd0, 5'd0, 0, 0, 0);
`ifdef WB_RETIRE_CNT_EN
    check("reset_cnt", retire_count, 64'd0);
`endif
    rst_n = 1'b1;

    drive(1, 5, 1, 2'd0, 3'd0, 64'h1234, 64'd0, 64'h100, 0, 0);
    step(); check_out("alu", 64'h1234, 5'd5, 1, 1, 0);

    drive(1, 6, 1, 2'd1, 3'b000, 64'h1001, 64'h80FF, 64'h104, 0, 0);
    step(); check_out("lb", 64'hFFFF_FFFF_FFFF_FF80, 5'd6, 1, 1, 0);
    drive(1, 6, 1, 2'd1, 3'b100, 64'h1001, 64'h80FF, 64'h108, 0, 0);
    step(); check_out("lbu", 64'h80, 5'd6, 1, 1, 0);

    drive(1, 9, 1, 2'd1, 3'b010, 64'h1002, 64'hFFFF_FFFF, 64'h10C, 0, 0);
    step(); check_out("lw_mis", 64'd0, 5'd9, 0, 1, 1);

    drive(1, 7, 1, 2'd2, 3'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0);
    step(); check_out("jal_wrap", 64'd0, 5'd7, 1, 1, 0);
    drive(1, 0, 1, 2'd2, 3'd0, 64'd0, 64'd0, 64'h200, 0, 0);
    step(); check_out("jal_rd0", 64'h204, 5'd0, 0, 1, 0);

    drive(1, 10, 1, 2'd1, 3'b011, 64'h2000, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0);
    step(); check_out("ld", 64'h0123_4567_89AB_CDEF, 5'd10, 1, 1, 0);
    drive(1, 11, 1, 2'd1, 3'b001, 64'h2006, 64'h8001_0000_0000_0000, 64'h0, 0, 0);
    step(); check_out("lh_hi", 64'hFFFF_FFFF_FFFF_8001, 5'd11, 1, 1, 0);
    drive(1, 12, 1, 2'd1, 3'b110, 64'h2004, 64'hDEAD_BEEF_0000_0000, 64'h0, 0, 0);
    step(); check_out("lwu", 64'h0000_0000_DEAD_BEEF, 5'd12, 1, 1, 0);
    drive(1, 12, 1, 2'd1, 3'b010, 64'h2004, 64'hDEAD_BEEF_0000_0000, 64'h0, 0, 0);
    step(); check_out("lw", 64'hFFFF_FFFF_DEAD_BEEF, 5'd12, 1, 1, 0);
    drive(1, 13, 1, 2'd1, 3'b111, 64'h2000, 64'h55, 64'h0, 0, 0);
    step(); check_out("f3_111", 64'd0, 5'd13, 0, 1, 1);
    drive(1, 14, 1, 2'd1, 3'b101, 64'h2001, 64'hFFFF, 64'h0, 0, 0);
    step(); check_out("lhu_mis", 64'd0, 5'd14, 0, 1, 1);
    drive(1, 15, 1, 2'd3, 3'd0, 64'h77, 64'd0, 64'h0, 0, 0);
    step(); check_out("sel11", 64'd0, 5'd15, 0, 1, 0);

    // Stall and flush together: bubble wins, old rd stays visible.
    drive(1, 16, 1, 2'd0, 3'd0, 64'hAAAA, 64'd0, 64'h0, 0, 0);
    step(); check_out("pre_flush", 64'hAAAA, 5'd16, 1, 1, 0);
    drive(1, 17, 1, 2'd0, 3'd0, 64'hBBBB, 64'd0, 64'h0, 1, 1);
    step();
    check("stall_flush_valid", {63'd0, wb_valid}, 64'd0);
    check("stall_flush_rd", {59'd0, rd}, 64'd16);
    check("stall_flush_we", {63'd0, RegWrite}, 64'd0);

    drive(1, 3, 1, 2'd0, 3'd0, 64'hCAFE, 64'd0, 64'h0, 0, 0);
    step(); check_out("held", 64'hCAFE, 5'd3, 1, 1, 0);
    c0 = m_cnt;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(20 + i), 1, 2'd0, 3'd0, 64'(i + 1), 64'd0, 64'h0, 1, 0);
      step(); check_out("stall_hold", 64'hCAFE, 5'd3, 1, 1, 0);
`ifdef WB_RETIRE_CNT_EN
      check("stall_cnt_hold", retire_count, c0);
`endif
    end
    drive(1, 4, 1, 2'd0, 3'd0, 64'hD00D, 64'd0, 64'h0, 0, 0);
    step(); check_out("release", 64'hD00D, 5'd4, 1, 1, 0);
`ifdef WB_RETIRE_CNT_EN
    check("stall_cnt_once", retire_count, c0 + 64'd1);
`endif

    // Reset between edges must clear outputs at once and override stall/flush.
    #2 rst_n = 1'b0;
    #1 check_out("async_rst", 64'd0, 5'd0, 0, 0, 0);
    drive(1, 8, 1, 2'd0, 3'd0, 64'h999, 64'd0, 64'h0, 1, 1);
    step(); check_out("rst_hold", 64'd0, 5'd0, 0, 0, 0);
`ifdef WB_RETIRE_CNT_EN
    check("rst_cnt", retire_count, 64'd0);
`endif
    #3 rst_n = 1'b1;
    drive(1, 8, 1, 2'd0, 3'd0, 64'h999, 64'd0, 64'h0, 0, 0);
    step(); check_out("post_rst", 64'h999, 5'd8, 1, 1, 0);

    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom), 5'($urandom), 1'($urandom), 2'($urandom), 3'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      step();
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
